// File: rtl/tdm_chan_muxdemux.sv
// tdm_chan_muxdemux: arbitrates N_CH producer channels onto one registered,
// channel-tagged bus (manual select or round-robin scan), then decodes that
// bus back into per-channel output registers with a one-cycle strobe.
// Optional macro TDM_PARITY_EN adds bus_par / par_err outputs and par_inj input.
module tdm_chan_muxdemux #(
  parameter  int unsigned N_CH  = 8,
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned HOLD  = 1,
  localparam int unsigned SELW  = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [SELW-1:0]       sel,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]      bus_data,
  output logic [SELW-1:0]       bus_ch,
  output logic                  bus_valid,
  output logic [N_CH*WIDTH-1:0] out_data,
  output logic [N_CH-1:0]       out_valid
`ifdef TDM_PARITY_EN
  ,
  input  logic                  par_inj,
  output logic                  bus_par,
  output logic                  par_err
`endif
);

  logic [SELW-1:0]       ptr_q, ptr_d;
  logic [WIDTH-1:0]      bus_data_q, bus_data_d;
  logic [SELW-1:0]       bus_ch_q, bus_ch_d;
  logic                  bus_valid_q, bus_valid_d;
  logic [N_CH*WIDTH-1:0] out_data_q, out_data_d;
  logic [N_CH-1:0]       out_valid_q, out_valid_d;

  logic                  gnt_vld;
  logic [SELW-1:0]       gnt_idx;
  logic [WIDTH-1:0]      gnt_data;
  int unsigned           idx;

  // Grant selection: manual select or first requester at/after ptr (wrapping)
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    if (mode) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        idx = 32'(ptr_q) + i;
        if (idx >= N_CH) idx = idx - N_CH;
        if (!gnt_vld && in_valid[SELW'(idx)]) begin
          gnt_vld = 1'b1;
          gnt_idx = SELW'(idx);
        end
      end
    end else begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        if (32'(sel) == c && in_valid[SELW'(c)]) begin
          gnt_vld = 1'b1;
          gnt_idx = SELW'(c);
        end
      end
    end
  end

  // One-hot grant, forced low while reset is asserted
  always_comb begin
    in_ready = '0;
    if (rst_n && gnt_vld) in_ready = N_CH'(1) << gnt_idx;
  end

  // Granted channel's data word
  always_comb begin
    gnt_data = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (gnt_idx == SELW'(c)) gnt_data = in_data[c*WIDTH +: WIDTH];
    end
  end

  // Mux stage and scan pointer next-state
  always_comb begin
    ptr_d       = ptr_q;
    bus_data_d  = bus_data_q;
    bus_ch_d    = bus_ch_q;
    bus_valid_d = gnt_vld;
    if (gnt_vld) begin
      bus_data_d = gnt_data;
      bus_ch_d   = gnt_idx;
      if (mode) ptr_d = (32'(gnt_idx) == N_CH - 1) ? '0 : SELW'(gnt_idx + 1'b1);
    end
  end

  // Demux stage next-state: write tagged channel, clear others when HOLD=0
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = '0;
    if (bus_valid_q) begin
      out_valid_d = N_CH'(1) << bus_ch_q;
      for (int unsigned c = 0; c < N_CH; c++) begin
        if (bus_ch_q == SELW'(c))
          out_data_d[c*WIDTH +: WIDTH] = bus_data_q;
        else if (HOLD == 0)
          out_data_d[c*WIDTH +: WIDTH] = '0;
      end
    end
  end

  // Pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      bus_data_q  <= '0;
      bus_ch_q    <= '0;
      bus_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      bus_data_q  <= bus_data_d;
      bus_ch_q    <= bus_ch_d;
      bus_valid_q <= bus_valid_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus_data  = bus_data_q;
  assign bus_ch    = bus_ch_q;
  assign bus_valid = bus_valid_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

`ifdef TDM_PARITY_EN
  logic bus_par_q, par_err_q;

  // Parity captured with the bus word; checked as it lands in the demux stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_par_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      if (gnt_vld) bus_par_q <= (^gnt_data) ^ par_inj;
      par_err_q <= bus_valid_q && ((^bus_data_q) != bus_par_q);
    end
  end

  assign bus_par = bus_par_q;
  assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_tdm_chan_muxdemux.sv
// Directed bench for tdm_chan_muxdemux: reset, manual select, manual miss,
// scan fairness, HOLD=1 vs HOLD=0, mid-operation reset and optional parity.
module tb_tdm_chan_muxdemux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [2:0]  sel;
  logic [63:0] in_data;
  logic [7:0]  in_valid;

  logic [7:0]  rdy_h, rdy_c;
  logic [7:0]  bd_h, bd_c;
  logic [2:0]  bc_h, bc_c;
  logic        bv_h, bv_c;
  logic [63:0] od_h, od_c;
  logic [7:0]  ov_h, ov_c;

  logic        mode6;
  logic [2:0]  sel6;
  logic [47:0] in_data6;
  logic [5:0]  in_valid6;
  logic [5:0]  rdy6;
  logic [7:0]  bd6;
  logic [2:0]  bc6;
  logic        bv6;
  logic [47:0] od6;
  logic [5:0]  ov6;

`ifdef TDM_PARITY_EN
  logic par_inj;
  logic bp_h, pe_h, bp_c, pe_c, bp6, pe6;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  tdm_chan_muxdemux #(.N_CH(8), .WIDTH(8), .HOLD(1)) dut_hold (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(rdy_h), .bus_data(bd_h), .bus_ch(bc_h),
    .bus_valid(bv_h), .out_data(od_h), .out_valid(ov_h)
`ifdef TDM_PARITY_EN
    , .par_inj(par_inj), .bus_par(bp_h), .par_err(pe_h)
`endif
  );

  tdm_chan_muxdemux #(.N_CH(8), .WIDTH(8), .HOLD(0)) dut_clr (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(rdy_c), .bus_data(bd_c), .bus_ch(bc_c),
    .bus_valid(bv_c), .out_data(od_c), .out_valid(ov_c)
`ifdef TDM_PARITY_EN
    , .par_inj(par_inj), .bus_par(bp_c), .par_err(pe_c)
`endif
  );

  tdm_chan_muxdemux #(.N_CH(6), .WIDTH(8), .HOLD(1)) dut_six (
    .clk(clk), .rst_n(rst_n), .mode(mode6), .sel(sel6), .in_data(in_data6),
    .in_valid(in_valid6), .in_ready(rdy6), .bus_data(bd6), .bus_ch(bc6),
    .bus_valid(bv6), .out_data(od6), .out_valid(ov6)
`ifdef TDM_PARITY_EN
    , .par_inj(1'b0), .bus_par(bp6), .par_err(pe6)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [63:0] oh;
  int          alt [4] = '{7, 0, 7, 0};

  initial begin
    rst_n = 1'b0; mode = 1'b1; sel = 3'd0; in_data = 64'h07060504_03020100;
    in_valid = 8'hFF;
    mode6 = 1'b0; sel6 = 3'd0; in_data6 = '0; in_valid6 = '0;
`ifdef TDM_PARITY_EN
    par_inj = 1'b0;
`endif
    // Reset with all channels requesting
    repeat (3) tick;
    check("rst_in_ready", 64'(rdy_h), 64'h00);
    check("rst_bus_valid", 64'(bv_h), 64'h0);
    check("rst_out_valid", 64'(ov_h), 64'h00);
    check("rst_out_data", od_h, 64'h0);
    rst_n = 1'b1;
    #1;
    check("rst_release_first_grant", 64'(rdy_h), 64'h01);
    in_valid = 8'h00;
    tick;

    // Manual select of channel 3
    mode = 1'b0; sel = 3'd3; in_valid = 8'h08; in_data = 64'h00000000_A5000000;
    #1;
    check("man_in_ready", 64'(rdy_h), 64'h08);
    tick;
    check("man_bus_valid", 64'(bv_h), 64'h1);
    check("man_bus_ch", 64'(bc_h), 64'h3);
    check("man_bus_data", 64'(bd_h), 64'hA5);
    in_valid = 8'h00;
    tick;
    check("man_out_valid", 64'(ov_h), 64'h08);
    check("man_out_ch3", 64'(od_h[31:24]), 64'hA5);

    // Manual miss: selected channel not requesting
    sel = 3'd5; in_valid = 8'h08;
    #1;
    check("miss_in_ready", 64'(rdy_h), 64'h00);
    tick;
    check("miss_bus_valid", 64'(bv_h), 64'h0);
    check("miss_bus_data_hold", 64'(bd_h), 64'hA5);

    // Six-channel instance: out-of-range select grants nothing
    in_valid6 = 6'h3F; sel6 = 3'd7;
    #1;
    check("six_sel7_ready", 64'(rdy6), 64'h00);
    tick;
    check("six_sel7_bus_valid", 64'(bv6), 64'h0);
    sel6 = 3'd5;
    #1;
    check("six_sel5_ready", 64'(rdy6), 64'h20);
    in_valid6 = '0;

    // Scan fairness: all requesting, pointer starts at 0
    mode = 1'b1; in_valid = 8'hFF; in_data = 64'h07060504_03020100;
    for (int k = 0; k < 10; k++) begin
      #1;
      oh = 64'(1) << (k % 8);
      check("scan_in_ready", 64'(rdy_h), oh);
      tick;
      check("scan_bus_ch", 64'(bc_h), 64'(k % 8));
      check("scan_bus_data", 64'(bd_h), 64'(k % 8));
      if (k > 0) begin
        oh = 64'(1) << ((k - 1) % 8);
        check("scan_out_valid", 64'(ov_h), oh);
      end
    end
    // Two requesters: pointer sits at 2, so 7 wins first
    in_valid = 8'h81;
    for (int k = 0; k < 4; k++) begin
      tick;
      check("scan_alt_bus_ch", 64'(bc_h), 64'(alt[k]));
    end
    in_valid = 8'h00;
    tick;

    // Mid-operation reset drops in-flight data
    in_valid = 8'hFF;
    tick;
    check("midrst_pre_bus_valid", 64'(bv_h), 64'h1);
    rst_n = 1'b0;
    #1;
    check("midrst_bus_valid", 64'(bv_h), 64'h0);
    check("midrst_in_ready", 64'(rdy_h), 64'h00);
    check("midrst_out_data", od_h, 64'h0);
    in_valid = 8'h00;
    rst_n = 1'b1;
    tick;
    check("midrst_no_strobe", 64'(ov_h), 64'h00);

    // HOLD behaviour: ch2 then ch4
    mode = 1'b0; sel = 3'd2; in_valid = 8'h04; in_data = 64'h00000022_00110000;
    tick;
    sel = 3'd4; in_valid = 8'h10;
    tick;
    in_valid = 8'h00;
    check("hold1_ch2_first", 64'(od_h[23:16]), 64'h11);
    check("hold0_ch2_first", 64'(od_c[23:16]), 64'h11);
    tick;
    check("hold1_ch2_kept", 64'(od_h[23:16]), 64'h11);
    check("hold1_ch4", 64'(od_h[39:32]), 64'h22);
    check("hold0_ch2_cleared", 64'(od_c[23:16]), 64'h00);
    check("hold0_all", od_c, 64'h00000022_00000000);
    check("hold_out_valid", 64'(ov_c), 64'h10);
    tick;
    check("idle_out_valid", 64'(ov_h), 64'h00);
    check("idle_out_data_hold", od_c, 64'h00000022_00000000);

`ifdef TDM_PARITY_EN
    // Parity: injected error on 8'h07, then clean transfer
    sel = 3'd3; in_valid = 8'h08; in_data = 64'h00000000_07000000; par_inj = 1'b1;
    tick;
    check("par_bus_par_inj", 64'(bp_h), 64'h0);
    in_valid = 8'h00; par_inj = 1'b0;
    tick;
    check("par_err_pulse", 64'(pe_h), 64'h1);
    check("par_err_align", 64'(ov_h), 64'h08);
    tick;
    check("par_err_one_cycle", 64'(pe_h), 64'h0);
    in_valid = 8'h08;
    tick;
    check("par_bus_par_clean", 64'(bp_h), 64'h1);
    in_valid = 8'h00;
    tick;
    check("par_err_clean", 64'(pe_h), 64'h0);
    check("par_clean_out_valid", 64'(ov_h), 64'h08);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tdm_chan_muxdemux.md
Name: tdm_chan_muxdemux

Overview:
- Parametrised, registered successor to the team's 8-input mux/demux.
- Arbitrates N_CH input channels onto one shared WIDTH-bit bus, tagged with a channel index.
- Decodes the bus back into N_CH per-channel output registers.
- Sits between channel producers and per-channel consumers on a single clock. Selection is either manual (select input) or automatic round-robin scan.

Parameters:
- N_CH, 8: channel count; legal range 2..64. SELW = clog2(N_CH) is derived internally and is not overridable.
- WIDTH, 8: data bits per channel.
- HOLD, 1: 1 = unselected out_data registers keep their last value; 0 = unselected out_data registers clear to 0 on every bus transfer.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = manual (use sel); 1 = round-robin scan.
- sel  in  SELW  manual channel select; values >= N_CH select nothing.
- in_data  in  N_CH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- in_valid  in  N_CH  per-channel request.
- in_ready  out  N_CH  one-hot grant, combinational; a transfer occurs when in_valid[c] && in_ready[c].
- bus_data  out  WIDTH  registered bus data.
- bus_ch  out  SELW  registered channel tag.
- bus_valid  out  1  registered bus strobe.
- out_data  out  N_CH*WIDTH  demultiplexed per-channel registers.
- out_valid  out  N_CH  one-cycle per-channel strobe.

Behaviour:
- Reset (rst_n low, asynchronous): bus_data=0, bus_ch=0, bus_valid=0, out_data=0, out_valid=0, scan pointer ptr=0. in_ready is 0 while rst_n is low.
- Grant, manual mode: grant = sel when sel < N_CH and in_valid[sel]=1; otherwise no grant. ptr is unchanged.
- Grant, scan mode: grant = first channel c with in_valid[c]=1, searching from ptr upward and wrapping N_CH-1 -> 0. No grant if in_valid=0.
  - On a grant, ptr <= grant+1, wrapping to 0 after N_CH-1.
  - With no grant, ptr holds.
- At most one bit of in_ready is set per cycle. in_ready[c] is set only when in_valid[c] is high.
- Mux stage, cycle t with a grant g: at edge t+1, bus_data <= in_data[g], bus_ch <= g, bus_valid <= 1.
- With no grant: bus_valid <= 0, and bus_data/bus_ch hold their values.
- Demux stage: when bus_valid=1, at the next edge out_data[bus_ch] <= bus_data and out_valid <= one-hot(bus_ch).
  - HOLD=0: all other out_data channels <= 0 on that edge.
  - HOLD=1: all other out_data channels hold.
  - When bus_valid=0: out_valid <= 0 and out_data holds, for both HOLD settings.
- Latency: input-accept to bus is 1 cycle; input-accept to out_data/out_valid is 2 cycles. Full throughput: one transfer per cycle, back-to-back.
- A mode or sel change takes effect on the grant in the same cycle (combinational). ptr is not reset by a mode change.
- Mid-operation reset clears both pipeline stages immediately. In-flight data is dropped, with no out_valid strobe.
- A single requester in scan mode is granted every cycle.

Optional Feature:
- Macro: TDM_PARITY_EN.
- When defined:
  - Extra output bus_par (1 bit, registered): even parity of in_data[g], captured alongside bus_data.
  - Extra output par_err (1 bit, registered, reset 0): pulses high one cycle with out_valid when the recomputed parity of bus_data differs from bus_par.
  - Extra input par_inj (1 bit): inverts bus_par at capture, for test only.
- When undefined: none of bus_par, par_err or par_inj exists, and there is no parity logic.

Test Plan:
- Reset: hold rst_n=0, drive in_valid=8'hFF -> in_ready=0, bus_valid=0, out_valid=0, out_data=0. Release rst_n -> scan grants ch0 first.
- Manual mode: mode=0, sel=3, in_valid=8'h08, in_data ch3=8'hA5 -> in_ready=8'h08; next cycle bus_ch=3, bus_data=8'hA5; following cycle out_valid=8'h08, out_data ch3=8'hA5.
- Manual miss: sel=5, in_valid[5]=0 -> in_ready=0 and bus_valid=0 next cycle. With N_CH=6, sel=7 -> no grant.
- Scan fairness: mode=1, in_valid=8'hFF held 10 cycles -> bus_ch sequence 0,1,…,7,0,1. Then in_valid=8'h81 -> grants alternate 7,0,7,0.
- HOLD: HOLD=1, write ch2=8'h11, then ch4=8'h22 -> ch2 still 8'h11. HOLD=0, same sequence -> ch2 becomes 0 when ch4 lands.
- Parity (TDM_PARITY_EN): send 8'h07 with par_inj=1 -> par_err pulses for one cycle aligned with out_valid. With par_inj=0 -> par_err stays 0.
